// File: rtl/uart_frame_assembler.sv
// Framing controller behind the UART receiver: hunts for a sync byte, collects a
// fixed-length payload, verifies its XOR checksum and offers the frame on valid/ready.
module uart_frame_assembler #(
    parameter int         INPUT_CLOCK_FREQ = 100_000_000,
    parameter int         BAUD_RATE        = 57600,
    parameter int         PAYLOAD_BYTES    = 4,
    parameter logic [7:0] SYNC_BYTE        = 8'hA5,
    parameter int         TIMEOUT_BAUDS    = 20
) (
    input  logic                       clk_in,
    input  logic                       rst_n_in,
    input  logic                       byte_valid_in,
    input  logic [7:0]                 byte_in,
    input  logic                       frame_ready_in,
    output logic                       frame_valid_out,
    output logic [8*PAYLOAD_BYTES-1:0] frame_data_out,
    output logic                       frame_error_out,
    output logic [1:0]                 error_code_out,
    output logic                       busy_out
);

    localparam int BIT_CYCLES     = INPUT_CLOCK_FREQ / BAUD_RATE;
    localparam int TIMEOUT_CYCLES = TIMEOUT_BAUDS * BIT_CYCLES;
    localparam int IDX_W          = $clog2(PAYLOAD_BYTES + 1);
    localparam int CNT_W          = $clog2(TIMEOUT_CYCLES + 1);
    localparam int DATA_W         = 8 * PAYLOAD_BYTES;

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PAYLOAD_BYTES - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] ERR_CHECKSUM = 2'b01;
    localparam logic [1:0] ERR_OVERRUN  = 2'b10;
    localparam logic [1:0] ERR_TIMEOUT  = 2'b11;

    typedef enum logic [1:0] {IDLE, PAYLOAD, CHECK, HOLD} state_t;

    state_t              state, state_next;
    logic [IDX_W-1:0]    idx, idx_next;
    logic [7:0]          chk, chk_next;
    logic [CNT_W-1:0]    cnt, cnt_next;
    logic [DATA_W-1:0]   buffer, buffer_next;
    logic                valid_next;
    logic [DATA_W-1:0]   data_next;
    logic                err_next;
    logic [1:0]          code_next;
    logic                busy_next;
    logic                handshake;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state           <= IDLE;
            idx             <= '0;
            chk             <= '0;
            cnt             <= '0;
            buffer          <= '0;
            frame_valid_out <= 1'b0;
            frame_data_out  <= '0;
            frame_error_out <= 1'b0;
            error_code_out  <= '0;
            busy_out        <= 1'b0;
        end else begin
            state           <= state_next;
            idx             <= idx_next;
            chk             <= chk_next;
            cnt             <= cnt_next;
            buffer          <= buffer_next;
            frame_valid_out <= valid_next;
            frame_data_out  <= data_next;
            frame_error_out <= err_next;
            error_code_out  <= code_next;
            busy_out        <= busy_next;
        end
    end

    assign handshake = frame_valid_out & frame_ready_in;

    // A byte arriving on the last allowed cycle is processed ahead of the timeout.
    always_comb begin
        state_next  = state;
        idx_next    = idx;
        chk_next    = chk;
        cnt_next    = cnt;
        buffer_next = buffer;
        valid_next  = frame_valid_out;
        data_next   = frame_data_out;
        err_next    = 1'b0;
        code_next   = error_code_out;

        case (state)
            IDLE: begin
                cnt_next = '0;
                if (byte_valid_in && byte_in == SYNC_BYTE) begin
                    state_next = PAYLOAD;
                    idx_next   = '0;
                    chk_next   = '0;
                end
            end
            PAYLOAD: begin
                if (byte_valid_in) begin
                    for (int i = 0; i < PAYLOAD_BYTES; i++) begin
                        if (idx == IDX_W'(i)) buffer_next[8*i +: 8] = byte_in;
                    end
                    chk_next = chk ^ byte_in;
                    idx_next = idx + 1'b1;
                    cnt_next = '0;
                    if (idx == IDX_LAST) state_next = CHECK;
                end else if (cnt == CNT_LAST) begin
                    err_next   = 1'b1;
                    code_next  = ERR_TIMEOUT;
                    cnt_next   = '0;
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            CHECK: begin
                if (byte_valid_in) begin
                    cnt_next = '0;
                    if (byte_in == chk) begin
                        data_next  = buffer;
                        valid_next = 1'b1;
                        state_next = HOLD;
                    end else begin
                        err_next   = 1'b1;
                        code_next  = ERR_CHECKSUM;
                        state_next = IDLE;
                    end
                end else if (cnt == CNT_LAST) begin
                    err_next   = 1'b1;
                    code_next  = ERR_TIMEOUT;
                    cnt_next   = '0;
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            HOLD: begin
                cnt_next = '0;
                if (handshake) begin
                    valid_next = 1'b0;
                    if (byte_valid_in && byte_in == SYNC_BYTE) begin
                        state_next = PAYLOAD;
                        idx_next   = '0;
                        chk_next   = '0;
                    end else begin
                        state_next = IDLE;
                    end
                end else if (byte_valid_in) begin
                    err_next  = 1'b1;
                    code_next = ERR_OVERRUN;
                end
            end
            default: state_next = IDLE;
        endcase

        busy_next = (state_next != IDLE);
    end

endmodule

// File: tb/tb_uart_frame_assembler.sv
// Directed bench for uart_frame_assembler: a byte-queue reference model checked every
// cycle, plus literal expectations at the interesting points of each scenario.
module tb_uart_frame_assembler;

    localparam int         CLK_FREQ       = 100_000_000;
    localparam int         BAUD           = 10_000_000;
    localparam int         P              = 4;
    localparam logic [7:0] SYNC           = 8'hA5;
    localparam int         TIMEOUT_CYCLES = 2 * (CLK_FREQ / BAUD);

    localparam int HUNT    = 0;
    localparam int COLLECT = 1;
    localparam int HOLDING = 2;

    logic           clk_in = 1'b0;
    logic           rst_n_in;
    logic           byte_valid_in;
    logic [7:0]     byte_in;
    logic           frame_ready_in;
    logic           frame_valid_out;
    logic [8*P-1:0] frame_data_out;
    logic           frame_error_out;
    logic [1:0]     error_code_out;
    logic           busy_out;

    int vectors    = 0;
    int miscompares = 0;
    logic check_en = 1'b0;

    uart_frame_assembler #(
        .INPUT_CLOCK_FREQ(CLK_FREQ),
        .BAUD_RATE(BAUD),
        .PAYLOAD_BYTES(P),
        .SYNC_BYTE(SYNC),
        .TIMEOUT_BAUDS(2)
    ) dut (
        .clk_in(clk_in),
        .rst_n_in(rst_n_in),
        .byte_valid_in(byte_valid_in),
        .byte_in(byte_in),
        .frame_ready_in(frame_ready_in),
        .frame_valid_out(frame_valid_out),
        .frame_data_out(frame_data_out),
        .frame_error_out(frame_error_out),
        .error_code_out(error_code_out),
        .busy_out(busy_out)
    );

    always #5 clk_in = ~clk_in;

    // Reference model: bytes after a sync are queued until payload plus checksum are in.
    int             phase     = HUNT;
    logic [7:0]     pend[$];
    int             quiet     = 0;
    logic           exp_valid = 1'b0;
    logic [8*P-1:0] exp_data  = '0;
    logic           exp_err   = 1'b0;
    logic [1:0]     exp_code  = 2'b00;

    always @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            phase     = HUNT;
            pend.delete();
            quiet     = 0;
            exp_valid = 1'b0;
            exp_data  = '0;
            exp_err   = 1'b0;
            exp_code  = 2'b00;
        end else begin
            exp_err = 1'b0;
            if (phase == HUNT) begin
                if (byte_valid_in && byte_in == SYNC) begin
                    phase = COLLECT;
                    pend.delete();
                    quiet = 0;
                end
            end else if (phase == COLLECT) begin
                if (byte_valid_in) begin
                    logic [7:0] x;
                    pend.push_back(byte_in);
                    quiet = 0;
                    if (pend.size() == P + 1) begin
                        x = 8'h00;
                        for (int i = 0; i < P; i++) x = x ^ pend[i];
                        if (x == pend[P]) begin
                            for (int i = 0; i < P; i++) exp_data[8*i +: 8] = pend[i];
                            exp_valid = 1'b1;
                            phase     = HOLDING;
                        end else begin
                            exp_err  = 1'b1;
                            exp_code = 2'b01;
                            phase    = HUNT;
                        end
                    end
                end else begin
                    quiet++;
                    if (quiet == TIMEOUT_CYCLES) begin
                        exp_err  = 1'b1;
                        exp_code = 2'b11;
                        phase    = HUNT;
                    end
                end
            end else begin
                if (frame_ready_in) begin
                    exp_valid = 1'b0;
                    if (byte_valid_in && byte_in == SYNC) begin
                        phase = COLLECT;
                        pend.delete();
                        quiet = 0;
                    end else begin
                        phase = HUNT;
                    end
                end else if (byte_valid_in) begin
                    exp_err  = 1'b1;
                    exp_code = 2'b10;
                end
            end
        end
    end

    task automatic check_output(input string name, input logic [31:0] actual,
                                input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    always @(negedge clk_in) begin
        if (check_en) begin
            check_output("valid", 32'(frame_valid_out), 32'(exp_valid));
            check_output("data", frame_data_out, exp_data);
            check_output("error", 32'(frame_error_out), 32'(exp_err));
            check_output("code", 32'(error_code_out), 32'(exp_code));
            check_output("busy", 32'(busy_out), 32'(phase != HUNT));
        end
    end

    task automatic send_byte(input logic [7:0] b);
        byte_valid_in = 1'b1;
        byte_in       = b;
        @(posedge clk_in); #1;
        byte_valid_in = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic apply_stimulus(input logic [7:0] b0, input logic [7:0] b1,
                                  input logic [7:0] b2, input logic [7:0] b3,
                                  input logic [7:0] cs);
        send_byte(SYNC);
        send_byte(b0);
        send_byte(b1);
        send_byte(b2);
        send_byte(b3);
        send_byte(cs);
    endtask

    task automatic handshake();
        frame_ready_in = 1'b1;
        @(posedge clk_in); #1;
        frame_ready_in = 1'b0;
        check_output("valid_after_ready", 32'(frame_valid_out), 32'd0);
    endtask

    initial begin
        rst_n_in       = 1'b0;
        byte_valid_in  = 1'b0;
        byte_in        = 8'h00;
        frame_ready_in = 1'b0;
        idle(3);
        check_output("reset_valid", 32'(frame_valid_out), 32'd0);
        check_output("reset_data", frame_data_out, 32'd0);
        check_output("reset_code", 32'(error_code_out), 32'd0);
        check_output("reset_busy", 32'(busy_out), 32'd0);
        #3 rst_n_in = 1'b1;
        check_en = 1'b1;
        idle(1);

        $display("[TB] good frame");
        apply_stimulus(8'h11, 8'h22, 8'h33, 8'h44, 8'h44);
        check_output("good_valid", 32'(frame_valid_out), 32'd1);
        check_output("good_data", frame_data_out, 32'h44332211);
        idle(3);
        check_output("good_hold", 32'(frame_valid_out), 32'd1);
        handshake();

        $display("[TB] bad checksum");
        apply_stimulus(8'h11, 8'h22, 8'h33, 8'h44, 8'h45);
        check_output("chk_err", 32'(frame_error_out), 32'd1);
        check_output("chk_code", 32'(error_code_out), 32'h1);
        check_output("chk_valid", 32'(frame_valid_out), 32'd0);
        idle(1);
        check_output("chk_err_gone", 32'(frame_error_out), 32'd0);
        check_output("chk_busy", 32'(busy_out), 32'd0);

        $display("[TB] garbage before sync");
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'h5A);
        check_output("garbage_busy", 32'(busy_out), 32'd0);
        apply_stimulus(8'h11, 8'h22, 8'h33, 8'h44, 8'h44);
        check_output("garbage_data", frame_data_out, 32'h44332211);
        handshake();

        $display("[TB] timeout");
        send_byte(SYNC);
        send_byte(8'h11);
        idle(TIMEOUT_CYCLES - 1);
        check_output("to_not_yet", 32'(frame_error_out), 32'd0);
        idle(1);
        check_output("to_err", 32'(frame_error_out), 32'd1);
        check_output("to_code", 32'(error_code_out), 32'h3);
        check_output("to_busy", 32'(busy_out), 32'd0);
        apply_stimulus(8'h11, 8'h22, 8'h33, 8'h44, 8'h44);
        check_output("to_recover", 32'(frame_valid_out), 32'd1);
        handshake();

        $display("[TB] byte on the last timeout cycle");
        send_byte(SYNC);
        send_byte(8'h11);
        idle(TIMEOUT_CYCLES - 1);
        send_byte(8'h22);
        check_output("late_no_err", 32'(frame_error_out), 32'd0);
        check_output("late_busy", 32'(busy_out), 32'd1);
        send_byte(8'h33);
        send_byte(8'h44);
        send_byte(8'h44);
        check_output("late_valid", 32'(frame_valid_out), 32'd1);

        $display("[TB] overrun");
        send_byte(8'h12);
        check_output("ovr_err", 32'(frame_error_out), 32'd1);
        check_output("ovr_code", 32'(error_code_out), 32'h2);
        check_output("ovr_data", frame_data_out, 32'h44332211);
        check_output("ovr_valid", 32'(frame_valid_out), 32'd1);

        $display("[TB] sync in handshake cycle");
        frame_ready_in = 1'b1;
        byte_valid_in  = 1'b1;
        byte_in        = SYNC;
        @(posedge clk_in); #1;
        frame_ready_in = 1'b0;
        byte_valid_in  = 1'b0;
        check_output("b2b_valid", 32'(frame_valid_out), 32'd0);
        check_output("b2b_busy", 32'(busy_out), 32'd1);
        check_output("b2b_err", 32'(frame_error_out), 32'd0);
        send_byte(8'hAA);
        send_byte(8'hBB);
        send_byte(8'hCC);
        send_byte(8'hDD);
        send_byte(8'h00);
        check_output("b2b_data", frame_data_out, 32'hDDCCBBAA);
        handshake();

        $display("[TB] reset mid-frame");
        send_byte(SYNC);
        send_byte(8'h11);
        #2 rst_n_in = 1'b0;
        #1;
        check_output("rst_busy", 32'(busy_out), 32'd0);
        check_output("rst_data", frame_data_out, 32'd0);
        check_output("rst_code", 32'(error_code_out), 32'd0);
        #2 rst_n_in = 1'b1;
        idle(1);
        send_byte(8'h22);
        send_byte(8'h33);
        check_output("rst_ignored", 32'(busy_out), 32'd0);
        apply_stimulus(8'h11, 8'h22, 8'h33, 8'h44, 8'h44);
        check_output("rst_recover", frame_data_out, 32'h44332211);
        handshake();
        idle(2);

        check_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/uart_frame_assembler.md
# uart_frame_assembler

Framing controller behind the UART receiver. It consumes the single-cycle byte strobes of the receiver and hunts for a sync byte. It assembles a fixed-length payload, verifies an XOR checksum and presents the completed frame to downstream logic over a valid/ready handshake. It also enforces an inter-byte timeout, so a broken transmission resynchronises instead of corrupting the next frame.

## Interface
Parameters:
- INPUT_CLOCK_FREQ, 100_000_000, clock frequency in Hz.
- BAUD_RATE, 57600, line rate; sets the bit period BIT_CYCLES = INPUT_CLOCK_FREQ / BAUD_RATE.
- PAYLOAD_BYTES, 4, payload length in bytes (≥1).
- SYNC_BYTE, 8'hA5, frame start marker.
- TIMEOUT_BAUDS, 20, inter-byte timeout in bit periods; TIMEOUT_CYCLES = TIMEOUT_BAUDS * BIT_CYCLES.

Ports:
- clk_in  input  1  system clock.
- rst_n_in  input  1  reset, asynchronous, active-low.
- byte_valid_in  input  1  one-cycle strobe, new received byte.
- byte_in  input  8  received byte, valid with byte_valid_in.
- frame_ready_in  input  1  downstream accepts frame.
- frame_valid_out  output  1  frame_data_out holds a verified frame.
- frame_data_out  output  8*PAYLOAD_BYTES  payload; first payload byte in [7:0].
- frame_error_out  output  1  one-cycle error pulse.
- error_code_out  output  2  cause of the last error: 01 checksum, 10 overrun, 11 timeout; holds until the next error.
- busy_out  output  1  high whenever state ≠ IDLE.

## Operation
- All outputs are registered.
- Reset (rst_n_in low, asynchronous) does the following:
  - state = IDLE;
  - all outputs are 0, including frame_data_out and error_code_out;
  - byte index, checksum and timeout counter are cleared.
- The assembly buffer and checksum are internal. frame_data_out is a separate register, loaded only on checksum success.
- Register widths:
  - byte index: $clog2(PAYLOAD_BYTES+1) bits;
  - timeout counter: $clog2(TIMEOUT_CYCLES+1) bits;
  - checksum: 8 bits, the XOR of the payload bytes only (the sync byte is excluded).
- IDLE:
  - byte == SYNC_BYTE → PAYLOAD; clear the index, checksum and timeout counter.
  - Any other byte is discarded silently, with no error.
- PAYLOAD, on each byte:
  - buffer[8*idx +: 8] = byte;
  - chk ^= byte;
  - idx++.
  - The byte with idx == PAYLOAD_BYTES-1 moves the block to CHECK.
- CHECK, on the next byte:
  - If byte == chk: load frame_data_out from the buffer, assert frame_valid_out, go to HOLD.
  - Otherwise: pulse frame_error_out, set error_code_out = 01, go to IDLE.
- HOLD:
  - frame_valid_out and frame_data_out stay stable until frame_valid_out & frame_ready_in.
  - On the handshake cycle, go to IDLE.
  - If the handshake cycle also carries byte == SYNC_BYTE, go directly to PAYLOAD (clearing the index and checksum), with no overrun.
  - Any byte in HOLD outside the handshake cycle: pulse error 10. The byte is dropped and the held frame is unchanged.
  - A non-sync byte in the handshake cycle is discarded silently.
- Timeout (PAYLOAD and CHECK only):
  - The counter is reset by every accepted byte and increments on every other cycle.
  - When the counter reaches TIMEOUT_CYCLES-1 with byte_valid_in low: pulse error 11, go to IDLE.
  - A byte arriving in that same cycle wins; it is processed normally and no timeout occurs.
  - The counter is held at 0 in IDLE and HOLD.
- frame_ready_in is ignored while frame_valid_out is low.

## Timing
- Byte acceptance: state and buffer update on the clock edge that samples byte_valid_in, so the next byte can be accepted one cycle later.
- Frame latency: frame_valid_out rises on the edge that samples the checksum byte strobe, i.e. visible the cycle after that strobe.
- Handshake: frame_valid_out falls on the edge that samples valid & ready.
- Error latency: frame_error_out is high for exactly one cycle, the cycle after the offending byte or timeout edge. error_code_out updates on the same edge.
- Back-to-back: the first byte of a new frame may arrive in the cycle after the handshake, or in the handshake cycle itself if it is the sync byte.
- Reset mid-operation clears everything immediately, without waiting for a clock edge. Any partial frame is lost, and no error is reported for it.

## Test plan
Defaults apply; reduce TIMEOUT_BAUDS to 2 and BAUD_RATE so that BIT_CYCLES = 10 for simulation speed.
- Good frame: A5 11 22 33 44 then checksum 44.
  - frame_valid_out rises the cycle after the checksum strobe, with frame_data_out = 32'h44332211.
  - The frame holds while ready is low; valid drops the cycle after ready is asserted.
- Bad checksum: A5 11 22 33 44 45 → frame_error_out pulses once with code 01; valid is never asserted; busy_out is 0 afterwards.
- Garbage before sync: 00 FF 5A then a good frame → no error pulses; frame_data_out = 32'h44332211.
- Timeout: A5 11 then silence for 20 cycles → error 11 on the 20th idle cycle, block returns to IDLE. A subsequent good frame is accepted.
  - Repeat with a byte strobe on exactly the 20th cycle: no timeout occurs.
- Overrun and handshake edge cases:
  - With the frame held and ready low, send byte 12 → error 10; frame_data_out is unchanged.
  - Assert ready in the same cycle as byte A5, then send AA BB CC DD with checksum 00 → second frame 32'hDDCCBBAA.
- Reset mid-frame: drop rst_n_in after A5 11 → all outputs 0 immediately. Bytes 22 33 are ignored; the next good frame is accepted.
